pipeline_hazard_ctrl: RTL

Central stall/flush controller for the five-stage pipeline. Every cycle it drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves three hazards:

- load-use data hazards, by inserting a bubble;
- taken branches resolved in EX, by flushing the two younger stages;
- multi-cycle data-memory accesses, by freezing the pipeline until `mem_ready`.

It also tracks stall and flush statistics and enters an error state on a memory timeout.

---
 rtl/pipeline_hazard_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use bubbles, EX branch
// flushes, data-memory freezes with timeout, and stall/flush statistics.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn_addr,
  input  logic                  id_rn_used,
  input  logic [REG_ADDR_W-1:0] id_rm_addr,
  input  logic                  id_rm_used,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_enable,
  output logic                  id_ex_flush,
  output logic                  ex_mem_enable,
  output logic                  mem_wb_enable,
  output logic                  mem_wb_flush,
  output logic                  mem_error,
  output logic [15:0]           stall_cycles,
  output logic [7:0]            flush_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_t;

  state_t             r_state;
  logic [WAIT_W-1:0]  r_wait;
  logic [15:0]        r_stall_cycles;
  logic [7:0]         r_flush_count;
  logic               r_mem_error;

  logic w_mem_stall;
  logic w_lu_hazard;
  logic w_freeze;
  logic w_branch_fire;

  assign w_mem_stall = mem_req & ~mem_ready;
  assign w_lu_hazard = ex_reg_write & ex_mem_to_reg &
                       ((id_rn_used & (id_rn_addr == ex_rd_addr)) |
                        (id_rm_used & (id_rm_addr == ex_rd_addr)));

  // A MEM_WAIT release cycle falls through to the normal RUN priority chain,
  // so hazards held during the freeze are resolved in that same cycle.
  assign w_freeze = ((r_state == S_RUN) & w_mem_stall) |
                    ((r_state == S_MEM_WAIT) & ~mem_ready) |
                    (r_state == S_ERROR);

  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    mem_wb_flush  = 1'b0;
    w_branch_fire = 1'b0;
    if (reset) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
    end else if (w_freeze) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_flush  = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      w_branch_fire = 1'b1;
    end else if (w_lu_hazard) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_RUN;
      r_wait         <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
      r_mem_error    <= 1'b0;
    end else begin
      if (!pc_enable && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_branch_fire && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 8'd1;

      case (r_state)
        S_RUN: begin
          if (w_mem_stall) begin
            r_state <= S_MEM_WAIT;
            r_wait  <= WAIT_W'(1);
          end
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            r_state <= S_RUN;
            r_wait  <= '0;
          end else if (r_wait == TIMEOUT_V) begin
            r_state     <= S_ERROR;
            r_mem_error <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_ERROR: ;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign mem_error    = r_mem_error;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule
